hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-004 SHALL have port signedOp, input, 1 bit: 1 = signed divide (fun 011010), 0 = unsigned (fun 011011).
REQ-005 SHALL have port dividend, input, 32 bits: rs operand; captured on the accepting edge.
REQ-006 SHALL have port divisor, input, 32 bits: rt operand; captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE; the pipeline stalls on it.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-009 SHALL have port hiloW, output, 1 bit: HI/LO write strobe; identical to done.
REQ-010 SHALL have port hi, output, 32 bits: remainder register.
REQ-011 SHALL have port lo, output, 32 bits: quotient register.
REQ-012 SHALL have port divByZero, output, 1 bit: sticky flag for the last operation; cleared on the next accepted start.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-014 In IDLE with start=1 and divisor!=0, SHALL capture operand magnitudes, sign info and signedOp, clear the step counter, and enter RUN.
REQ-015 In IDLE with start=1 and divisor==0, SHALL set divByZero, load lo=32'hFFFFFFFF and hi=dividend (raw), and enter DONE.
REQ-016 In RUN, SHALL perform one restoring shift-subtract quotient bit per cycle, MSB first, with a 33-bit partial remainder; after exactly 32 RUN cycles it SHALL enter FIX.
REQ-017 In FIX, SHALL load lo and hi; when signedOp=1, quotient is negated if the operand signs differ, and remainder takes the dividend's sign; unsigned results are loaded unchanged; then enter DONE.
REQ-018 In DONE, SHALL assert done=hiloW=1 for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be: accept edge to done high = 34 cycles normally, 1 cycle for divide-by-zero.
REQ-020 While busy, start SHALL be ignored, and dividend/divisor changes SHALL have no effect.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new divide SHALL be accepted only from IDLE on the following cycle.
REQ-022 Signed overflow (32'h80000000 / 32'hFFFFFFFF) SHALL yield lo=32'h80000000, hi=0, with no flag.
REQ-023 Magnitude of 32'h80000000 SHALL be treated as unsigned 2^31, with no overflow.
REQ-024 hi and lo SHALL change only in FIX or on the divide-by-zero path, and SHALL otherwise hold the last result.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, hiloW=0, hi=0, lo=0, divByZero=0, and clear all internal registers.
REQ-026 rst asserted mid-operation SHALL abort the divide with no hiloW pulse; operation SHALL resume from IDLE on the first edge after rst deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2 bits), DIV_CYCLES=32 and DATA_W=32.
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring step: inputs partial remainder and next dividend bit, outputs new remainder and quotient bit.
REQ-029 The counter SHALL be 6 bits wide, and the FSM SHALL use no other sub-modules.

Verification
REQ-030 Unsigned: 100 / 7 -> done at cycle 34 with lo=14, hi=2, hiloW for one cycle.
REQ-031 Signed: -7 / 2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); 7 / -2 -> lo=-3, hi=1.
REQ-032 Divide-by-zero: 5 / 0 -> done after 1 cycle, lo=32'hFFFFFFFF, hi=5, divByZero=1; the next valid start clears the flag.
REQ-033 Overflow: signed 32'h80000000 / -1 -> lo=32'h80000000, hi=0; unsigned 32'hFFFFFFFF / 1 -> lo=32'hFFFFFFFF, hi=0.
REQ-034 start held high through a divide, with operands changed at cycle 10 -> result reflects the original operands, and exactly one hiloW pulse occurs per accept.
REQ-035 rst pulsed at RUN cycle 15 -> busy drops immediately, hi/lo=0, no done pulse; a following 9 / 3 gives lo=3, hi=0.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_div_ctrl_pkg
// Shared definitions for the HI/LO divide controller:
//   - stateT     : 2-bit FSM state encoding (IDLE, RUN, FIX, DONE)
//   - DATA_W     : operand / result width
//   - DIV_CYCLES : number of restoring shift-subtract steps per divide
//   - magnitude  : absolute value helper for signed operands
package hilo_div_ctrl_pkg;

   localparam int DATA_W     = 32;
   localparam int DIV_CYCLES = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } stateT;

   // Returns the unsigned magnitude of v. For a signed operand the most
   // negative value 32'h80000000 maps to itself, which read as unsigned is
   // exactly 2^31, so no overflow case needs special handling.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic              isSigned);
      return (isSigned && v[DATA_W-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// div_step
// One combinational restoring-division step.
// Ports:
//   remIn     : partial remainder before this step (DATA_W+1 bits)
//   bitIn     : next dividend bit, MSB first
//   divisorIn : divisor magnitude
//   remOut    : partial remainder after this step
//   qBit      : quotient bit produced by this step
module div_step
   import hilo_div_ctrl_pkg::*;
(
   input  logic [DATA_W:0]   remIn,
   input  logic              bitIn,
   input  logic [DATA_W-1:0] divisorIn,
   output logic [DATA_W:0]   remOut,
   output logic              qBit
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   // Shift the next dividend bit into the remainder, then subtract the
   // divisor if it fits. A set top bit of remIn means the shifted value is
   // at least 2^(DATA_W+1), which always exceeds the divisor; the modulo
   // subtraction below still yields the right remainder in that case.
   always_comb begin
      shifted = {remIn[DATA_W-1:0], bitIn};
      diff    = shifted - {1'b0, divisorIn};
      qBit    = remIn[DATA_W] | (shifted >= {1'b0, divisorIn});
      remOut  = qBit ? diff : shifted;
   end

endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
// Multi-cycle DIV/DIVU controller writing the HI (remainder) and LO
// (quotient) registers. One restoring step per cycle, 32 steps, then a
// sign-fixup cycle and a one-cycle done/hiloW pulse.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : divide request, honoured only in IDLE
//   signedOp            : 1 = signed (DIV), 0 = unsigned (DIVU)
//   dividend, divisor   : rs / rt operands, captured when start is accepted
//   busy                : high whenever the FSM is not IDLE
//   done, hiloW         : one-cycle result-valid / HI-LO write strobe
//   hi, lo              : remainder / quotient of the last operation
//   divByZero           : set when the last operation had a zero divisor
module hilo_div_ctrl
   import hilo_div_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signedOp,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic              hiloW,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              divByZero
);

   localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

   stateT             state_q;
   logic              busy_q;
   logic              done_q;
   logic              dbz_q;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W:0]   rem_q;
   logic [DATA_W-1:0] dvd_q;
   logic [DATA_W-1:0] dvs_q;
   logic [5:0]        cnt_q;
   logic              signed_q;
   logic              dvdSign_q;
   logic              dvsSign_q;

   logic [DATA_W:0]   rem_d;
   logic              qBit_d;

   // The dividend register doubles as the quotient register: each step
   // consumes its MSB and shifts the new quotient bit in at the LSB, so
   // after the last step it holds the unsigned quotient.
   div_step uStep (
      .remIn     (rem_q),
      .bitIn     (dvd_q[DATA_W-1]),
      .divisorIn (dvs_q),
      .remOut    (rem_d),
      .qBit      (qBit_d)
   );

   // Whole controller as one registered FSM. busy and done are registered
   // alongside the state so they come straight from flops. hi/lo only move
   // in FIX or on the zero-divisor shortcut, so they keep the last result
   // throughout a following divide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         signed_q  <= 1'b0;
         dvdSign_q <= 1'b0;
         dvsSign_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (divisor == '0) begin
                     dbz_q   <= 1'b1;
                     lo_q    <= '1;
                     hi_q    <= dividend;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     dbz_q     <= 1'b0;
                     dvd_q     <= magnitude(dividend, signedOp);
                     dvs_q     <= magnitude(divisor, signedOp);
                     rem_q     <= '0;
                     cnt_q     <= '0;
                     signed_q  <= signedOp;
                     dvdSign_q <= dividend[DATA_W-1];
                     dvsSign_q <= divisor[DATA_W-1];
                     state_q   <= RUN;
                  end
               end
            end
            RUN: begin
               rem_q <= rem_d;
               dvd_q <= {dvd_q[DATA_W-2:0], qBit_d};
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == LAST_STEP) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               // Quotient is negative when the signs differ; the remainder
               // follows the dividend's sign, as DIV requires.
               lo_q    <= (signed_q && (dvdSign_q ^ dvsSign_q)) ? (~dvd_q + 1'b1) : dvd_q;
               hi_q    <= (signed_q && dvdSign_q) ? (~rem_q[DATA_W-1:0] + 1'b1)
                                                  : rem_q[DATA_W-1:0];
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign hiloW     = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign divByZero = dbz_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl
// Directed self-checking bench for hilo_div_ctrl. Expected quotients,
// remainders and latencies are hand-computed constants.
module tb_hilo_div_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        signedOp;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        hiloW;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        divByZero;

   int checkCount;
   int errorCount;

   hilo_div_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .signedOp  (signedOp),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .hiloW     (hiloW),
      .hi        (hi),
      .lo        (lo),
      .divByZero (divByZero)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Launches one divide, waits (bounded) for done, then checks latency,
   // results, flag, strobe, and that the strobe lasts exactly one cycle.
   // Latency counts the accept edge as cycle 1.
   task automatic applyStimulus(input string tag, input logic sgn,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expLo, input logic [31:0] expHi,
                                input logic expDbz, input int expLat);
      int lat;
      @(negedge clk);
      start    = 1'b1;
      signedOp = sgn;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, " lo"}, lo, expLo);
      checkOutput({tag, " hi"}, hi, expHi);
      checkOutput({tag, " divByZero"}, 32'(divByZero), 32'(expDbz));
      checkOutput({tag, " hiloW"}, 32'(hiloW), 32'd1);
      @(posedge clk);
      #1;
      checkOutput({tag, " done width"}, 32'(done), 32'd0);
      checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
   endtask

   // Directed sequence: reset, arithmetic vectors, zero divisor, overflow,
   // held start with changing operands, and reset mid-divide.
   initial begin
      int lat;
      int pulses;
      int doneSeen;
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      start      = 1'b0;
      signedOp   = 1'b0;
      dividend   = '0;
      divisor    = '0;

      #12;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset hiloW", 32'(hiloW), 32'd0);
      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      checkOutput("reset dbz", 32'(divByZero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      applyStimulus("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
      applyStimulus("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 34);
      applyStimulus("s-7/-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 34);
      applyStimulus("u-7/2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 34);
      applyStimulus("dbz5/0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);
      applyStimulus("u9/3 after dbz", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
      applyStimulus("dbz-5/0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1);
      applyStimulus("s-2^31/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);
      applyStimulus("uFFFFFFFF/1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
      applyStimulus("s-2^31/2", 1'b1, 32'h80000000, 32'd2, 32'hC0000000, 32'd0, 1'b0, 34);

      // Start held high; operands change mid-divide and start stays high
      // through the DONE cycle, which must not re-accept.
      @(negedge clk);
      start    = 1'b1;
      signedOp = 1'b0;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(posedge clk);
      #1;
      lat    = 1;
      pulses = 0;
      while (!done && lat < 60) begin
         if (lat == 10) begin
            dividend = 32'd50;
            divisor  = 32'd5;
         end
         @(posedge clk);
         #1;
         lat++;
         if (hiloW) pulses++;
      end
      checkOutput("held latency", 32'(lat), 32'd34);
      checkOutput("held lo", lo, 32'd14);
      checkOutput("held hi", hi, 32'd2);
      @(posedge clk);
      #1;
      if (hiloW) pulses++;
      checkOutput("held pulses", 32'(pulses), 32'd1);
      checkOutput("start in DONE ignored", 32'(busy), 32'd0);
      start = 1'b0;

      // Reset mid-RUN: busy drops immediately, results clear, no pulse.
      @(negedge clk);
      start    = 1'b1;
      signedOp = 1'b0;
      dividend = 32'd100;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("hold lo while busy", lo, 32'd14);
      checkOutput("busy mid-run", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort hi", hi, 32'd0);
      checkOutput("abort lo", lo, 32'd0);
      doneSeen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (done || hiloW) doneSeen++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || hiloW) doneSeen++;
      end
      checkOutput("abort no pulse", 32'(doneSeen), 32'd0);
      applyStimulus("u9/3 after rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
